// File: rtl/logs_r_sequencer_pkg.sv
// Shared types and the default segment playlist for the logistic-map r sequencer.
// The playlist is authored in 2.8 fixed point and rescaled by the ROM for other FRAC values.
package logs_r_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_PLAY    = 2'd2,
      ST_ADVANCE = 2'd3
   } seq_state_t;

   localparam int         TABLE_FRAC = 8;
   localparam logic [9:0] INITIAL_R  = 10'h110;

   typedef struct packed {
      logic [9:0]  start_r;
      logic [9:0]  end_r;
      logic [9:0]  step;
      logic [15:0] dwell;
   } seg_entry_t;

   function automatic seg_entry_t seg_table(input logic [1:0] idx);
      seg_entry_t e;
      case (idx)
         2'd0:    e = '{start_r: 10'h110, end_r: 10'h2FF, step: 10'd4, dwell: 16'd1000};
         2'd1:    e = '{start_r: 10'h300, end_r: 10'h390, step: 10'd1, dwell: 16'd1000};
         2'd2:    e = '{start_r: 10'h3D4, end_r: 10'h3D4, step: 10'd0, dwell: 16'd4000};
         default: e = '{start_r: 10'h390, end_r: 10'h3FF, step: 10'd1, dwell: 16'd1000};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/logs_r_sequencer_seg_rom.sv
// Combinational playlist lookup: segment index -> start r, end r, step and dwell.
module logs_r_sequencer_seg_rom
   import logs_r_sequencer_pkg::*;
#(
   parameter int FRAC       = 8,
   parameter int SEG_W      = 2,
   parameter int DWELL_BITS = 16,
   localparam int RW        = FRAC + 2
) (
   input  logic [SEG_W-1:0]      seg,
   output logic [RW-1:0]         start_r,
   output logic [RW-1:0]         end_r,
   output logic [RW-1:0]         step,
   output logic [DWELL_BITS-1:0] dwell
);

   logic [1:0] idx;
   seg_entry_t entry;

   assign idx   = 2'(seg);
   assign entry = seg_table(idx);
   assign dwell = DWELL_BITS'(entry.dwell);

   // Table values are 2.8; shift them onto the configured fractional grid.
   generate
      if (FRAC >= TABLE_FRAC) begin : g_scale_up
         assign start_r = RW'(entry.start_r) << (FRAC - TABLE_FRAC);
         assign end_r   = RW'(entry.end_r)   << (FRAC - TABLE_FRAC);
         assign step    = RW'(entry.step)    << (FRAC - TABLE_FRAC);
      end else begin : g_scale_down
         assign start_r = RW'(entry.start_r >> (TABLE_FRAC - FRAC));
         assign end_r   = RW'(entry.end_r   >> (TABLE_FRAC - FRAC));
         assign step    = RW'(entry.step    >> (TABLE_FRAC - FRAC));
      end
   endgenerate

endmodule

// File: rtl/logs_r_sequencer.sv
// Steps the logistic-map r parameter through a playlist of segments, muting audio
// while the map settles after each jump and qualifying next_ready pulses during play.
module logs_r_sequencer
   import logs_r_sequencer_pkg::*;
#(
   parameter int FRAC           = 8,
   parameter int N_SEG          = 4,
   parameter int SETTLE         = 64,
   parameter int DWELL_BITS     = 16,
   parameter int DWELL_OVERRIDE = 0,
   localparam int RW            = FRAC + 2,
   localparam int SEG_W         = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             next_ready,
   input  logic             hold,
   input  logic             skip,
   output logic [RW-1:0]    r,
   output logic             x_use,
   output logic             mute,
   output logic             reseed,
   output logic [SEG_W-1:0] seg
);

   localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   seq_state_t state_q, state_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic [RW-1:0]         r_q, r_d;
   logic [SET_W-1:0]      set_cnt_q, set_cnt_d;
   logic [DWELL_BITS-1:0] dwell_cnt_q, dwell_cnt_d;

   logic [RW-1:0]         rom_start;
   logic [RW-1:0]         rom_end;
   logic [RW-1:0]         rom_step;
   logic [DWELL_BITS-1:0] rom_dwell;

   logic [SET_W-1:0]      set_inc;
   logic [DWELL_BITS:0]   dwell_inc;
   logic [DWELL_BITS:0]   dwell_target;
   logic                  dwell_done;
   logic [RW:0]           r_nxt;
   logic                  step_stop;
   logic [SEG_W-1:0]      seg_wrap;
   logic [RW-1:0]         reset_r;

   logs_r_sequencer_seg_rom #(
      .FRAC       (FRAC),
      .SEG_W      (SEG_W),
      .DWELL_BITS (DWELL_BITS)
   ) u_seg_rom (
      .seg     (seg_q),
      .start_r (rom_start),
      .end_r   (rom_end),
      .step    (rom_step),
      .dwell   (rom_dwell)
   );

   generate
      if (FRAC >= TABLE_FRAC) begin : g_reset_up
         assign reset_r = RW'(INITIAL_R) << (FRAC - TABLE_FRAC);
      end else begin : g_reset_down
         assign reset_r = RW'(INITIAL_R >> (TABLE_FRAC - FRAC));
      end
   endgenerate

   assign set_inc      = set_cnt_q + 1'b1;
   assign dwell_inc    = {1'b0, dwell_cnt_q} + 1'b1;
   assign dwell_target = (DWELL_OVERRIDE != 0) ? (DWELL_BITS + 1)'(DWELL_OVERRIDE)
                                               : {1'b0, rom_dwell};
   assign dwell_done   = (dwell_inc >= dwell_target);

   // One extra bit so an r step past 4.0 is caught instead of wrapping.
   assign r_nxt     = {1'b0, r_q} + {1'b0, rom_step};
   assign step_stop = (rom_step == '0) || (r_nxt > {1'b0, rom_end}) || r_nxt[RW];
   assign seg_wrap  = (seg_q == SEG_W'(N_SEG - 1)) ? '0 : seg_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         seg_q       <= '0;
         r_q         <= reset_r;
         set_cnt_q   <= '0;
         dwell_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         seg_q       <= seg_d;
         r_q         <= r_d;
         set_cnt_q   <= set_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
      end
   end

   // Skip outranks both hold and the dwell/step decision so a segment is left exactly once.
   always_comb begin
      state_d     = state_q;
      seg_d       = seg_q;
      r_d         = r_q;
      set_cnt_d   = set_cnt_q;
      dwell_cnt_d = dwell_cnt_q;

      if (skip && (state_q != ST_ADVANCE)) begin
         state_d = ST_ADVANCE;
      end else if (!hold) begin
         case (state_q)
            ST_LOAD: begin
               r_d         = rom_start;
               set_cnt_d   = '0;
               dwell_cnt_d = '0;
               state_d     = (SETTLE == 0) ? ST_PLAY : ST_SETTLE;
            end
            ST_SETTLE: begin
               if (next_ready) begin
                  set_cnt_d = set_inc;
                  if (set_inc == SET_W'(SETTLE)) begin
                     state_d = ST_PLAY;
                  end
               end
            end
            ST_PLAY: begin
               if (next_ready) begin
                  if (dwell_done) begin
                     dwell_cnt_d = '0;
                     if (step_stop) begin
                        state_d = ST_ADVANCE;
                     end else begin
                        r_d = r_nxt[RW-1:0];
                     end
                  end else begin
                     dwell_cnt_d = dwell_inc[DWELL_BITS-1:0];
                  end
               end
            end
            default: begin
               seg_d   = seg_wrap;
               state_d = ST_LOAD;
            end
         endcase
      end
   end

   assign r      = r_q;
   assign seg    = seg_q;
   assign x_use  = next_ready && (state_q == ST_PLAY);
   assign mute   = (state_q != ST_PLAY);
   assign reseed = (state_q == ST_LOAD);

endmodule

// File: tb/tb_logs_r_sequencer.sv
// Directed bench for logs_r_sequencer with a short settle and dwell, and a
// next_ready pulse every fourth clock.
module tb_logs_r_sequencer;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       next_ready = 1'b0;
   logic       hold       = 1'b0;
   logic       skip       = 1'b0;
   logic [9:0] r;
   logic       x_use;
   logic       mute;
   logic       reseed;
   logic [1:0] seg;

   int         assertCount  = 0;
   int         failCount    = 0;
   logic       pulseEnable  = 1'b0;
   int         pulsePhase   = 0;
   int         settlePulses = 0;
   logic       settleXuse   = 1'b0;
   logic [9:0] lastR;
   int         waitCount;

   logs_r_sequencer #(
      .FRAC           (8),
      .N_SEG          (4),
      .SETTLE         (2),
      .DWELL_BITS     (16),
      .DWELL_OVERRIDE (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .next_ready (next_ready),
      .hold       (hold),
      .skip       (skip),
      .r          (r),
      .x_use      (x_use),
      .mute       (mute),
      .reseed     (reseed),
      .seg        (seg)
   );

   always #5 clk = ~clk;

   // One-cycle next_ready pulse every four clocks, launched just after a rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (pulseEnable) begin
            pulsePhase = pulsePhase + 1;
            next_ready = ((pulsePhase % 4) == 0);
         end else begin
            next_ready = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic skipValue, input logic holdValue);
      skip = skipValue;
      hold = holdValue;
   endtask

   // Returns at the falling edge where the n-th further pulse is visible.
   task automatic waitPulses(input int n);
      for (int k = 0; k < n; k++) begin
         int w;
         w = 0;
         @(negedge clk);
         while (!next_ready && (w < 50)) begin
            @(negedge clk);
            w++;
         end
         if (w >= 50) checkOutput("pulse_timeout", 32'(next_ready), 32'd1);
      end
   endtask

   task automatic waitPlay(input string tag);
      int w;
      w = 0;
      @(negedge clk);
      while (mute && (w < 200)) begin
         @(negedge clk);
         w++;
      end
      checkOutput(tag, 32'(mute), 32'd0);
   endtask

   task automatic pulseSkip();
      applyStimulus(1'b1, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0);
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      checkOutput("rst_r",      32'(r),      32'h110);
      checkOutput("rst_seg",    32'(seg),    32'd0);
      checkOutput("rst_mute",   32'(mute),   32'd1);
      checkOutput("rst_reseed", 32'(reseed), 32'd1);
      checkOutput("rst_xuse",   32'(x_use),  32'd0);

      rst_n       = 1'b1;
      pulseEnable = 1'b1;
      @(negedge clk);
      checkOutput("settle_reseed", 32'(reseed), 32'd0);
      checkOutput("settle_mute",   32'(mute),   32'd1);
      checkOutput("settle_r",      32'(r),      32'h110);

      // Mute must hold for exactly two pulses after LOAD
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!mute) break;
         if (next_ready) settlePulses++;
         settleXuse = settleXuse | x_use;
      end
      checkOutput("settle_reached", 32'(mute), 32'd0);
      checkOutput("settle_pulses",  32'(settlePulses), 32'd2);
      checkOutput("settle_xuse",    32'(settleXuse), 32'd0);
      checkOutput("play_r0",        32'(r), 32'h110);

      // Seg0 sweep: x_use follows pulses, r += 4 every third pulse
      waitPulses(1);
      checkOutput("xuse_pulse", 32'(x_use), 32'd1);
      @(negedge clk);
      checkOutput("xuse_idle", 32'(x_use), 32'd0);
      checkOutput("r_hold_mid_dwell", 32'(r), 32'h110);
      waitPulses(2);
      @(negedge clk);
      checkOutput("r_step1", 32'(r), 32'h114);
      waitPulses(3);
      @(negedge clk);
      checkOutput("r_step2", 32'(r), 32'h118);

      // Seg0 end and move to seg1
      lastR = r;
      waitCount = 0;
      while ((seg != 2'd1) && (waitCount < 4000)) begin
         lastR = r;
         @(negedge clk);
         waitCount++;
      end
      checkOutput("seg1_reached", 32'(seg), 32'd1);
      checkOutput("seg0_last_r",  32'(lastR), 32'h2FC);
      checkOutput("seg1_reseed",  32'(reseed), 32'd1);
      checkOutput("seg1_load_r",  32'(r), 32'h2FC);
      @(negedge clk);
      checkOutput("seg1_reseed_off", 32'(reseed), 32'd0);
      checkOutput("seg1_start_r",    32'(r), 32'h300);

      // Skip on the same edge as a dwell end in seg1
      waitPlay("seg1_play");
      waitPulses(3);
      pulseSkip();
      @(negedge clk);
      checkOutput("skip_adv_mute", 32'(mute), 32'd1);
      checkOutput("skip_adv_seg",  32'(seg),  32'd1);
      checkOutput("skip_no_step",  32'(r),    32'h300);
      @(negedge clk);
      checkOutput("skip_seg2",        32'(seg),    32'd2);
      checkOutput("skip_load_reseed", 32'(reseed), 32'd1);
      @(negedge clk);
      checkOutput("seg2_r", 32'(r),   32'h3D4);
      checkOutput("seg2_seg", 32'(seg), 32'd2);

      // Hold for 20 pulses in seg2
      waitPlay("seg2_play");
      applyStimulus(1'b0, 1'b1);
      waitPulses(20);
      checkOutput("hold_xuse", 32'(x_use), 32'd1);
      @(negedge clk);
      checkOutput("hold_r",    32'(r),    32'h3D4);
      checkOutput("hold_seg",  32'(seg),  32'd2);
      checkOutput("hold_mute", 32'(mute), 32'd0);
      applyStimulus(1'b0, 1'b0);
      waitPulses(3);
      @(negedge clk);
      checkOutput("seg2_adv_mute", 32'(mute), 32'd1);
      checkOutput("seg2_adv_seg",  32'(seg),  32'd2);
      @(negedge clk);
      checkOutput("seg3_reached", 32'(seg), 32'd3);
      @(negedge clk);
      checkOutput("seg3_start_r", 32'(r), 32'h390);

      // Seg3 runs to 0x3FF then wraps to seg0
      waitCount = 0;
      while ((seg != 2'd0) && (waitCount < 3000)) begin
         lastR = r;
         @(negedge clk);
         waitCount++;
      end
      checkOutput("wrap_seg0",    32'(seg),    32'd0);
      checkOutput("seg3_last_r",  32'(lastR),  32'h3FF);
      checkOutput("wrap_reseed",  32'(reseed), 32'd1);
      @(negedge clk);
      checkOutput("wrap_r", 32'(r), 32'h110);

      // Three skips walk seg0 -> seg3
      for (int i = 0; i < 3; i++) begin
         waitPlay("skip_walk_play");
         pulseSkip();
      end
      waitPlay("seg3b_play");
      checkOutput("skip_walk_seg", 32'(seg), 32'd3);
      waitPulses(7);
      @(negedge clk);
      checkOutput("seg3b_r", 32'(r), 32'h392);

      // Asynchronous reset mid-PLAY
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_r",      32'(r),      32'h110);
      checkOutput("arst_seg",    32'(seg),    32'd0);
      checkOutput("arst_mute",   32'(mute),   32'd1);
      checkOutput("arst_reseed", 32'(reseed), 32'd1);
      checkOutput("arst_xuse",   32'(x_use),  32'd0);

      pulseEnable = 1'b0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
